// File: rtl/ctrl_pipe_pkg.sv
// ctrl_pipe_pkg: shared definitions for the pipelined main-control unit.
//   - RV32I major opcodes
//   - 11-bit control bundle layout {alu_op[3:0],exec_a,exec_b,mem_w,reg_w,mem2reg,bra,jmp}
//   - per-opcode control bundles
//   - register-usage helpers used by load-use hazard detection
package ctrl_pipe_pkg;

   localparam int CTRL_W    = 11;

   // bit positions inside the control bundle
   localparam int ALUOP_LSB = 7;
   localparam int EXEC_A    = 6;
   localparam int EXEC_B    = 5;
   localparam int MEM_W     = 4;
   localparam int REG_W     = 3;
   localparam int MEM2REG   = 2;
   localparam int BRA       = 1;
   localparam int JMP       = 0;

   localparam logic [6:0] OP_R       = 7'b0110011;
   localparam logic [6:0] OP_I_JUMP  = 7'b1100111;  // jalr
   localparam logic [6:0] OP_I_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_I_ARITH = 7'b0010011;
   localparam logic [6:0] OP_I_SYS   = 7'b1110011;
   localparam logic [6:0] OP_I_FENCE = 7'b0001111;
   localparam logic [6:0] OP_S       = 7'b0100011;
   localparam logic [6:0] OP_B       = 7'b1100011;
   localparam logic [6:0] OP_U_LUI   = 7'b0110111;
   localparam logic [6:0] OP_U_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_J       = 7'b1101111;  // jal

   //                                          alu    a    b    mw   rw   m2r  bra  jmp
   localparam logic [CTRL_W-1:0] R_CTRL       = {4'h2, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0};
   localparam logic [CTRL_W-1:0] I_JUMP_CTRL  = {4'h0, 1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b1};
   localparam logic [CTRL_W-1:0] I_LOAD_CTRL  = {4'h0, 1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,1'b0};
   localparam logic [CTRL_W-1:0] I_ARITH_CTRL = {4'h3, 1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0};
   localparam logic [CTRL_W-1:0] I_SYS_CTRL   = {4'h5, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
   localparam logic [CTRL_W-1:0] I_FENCE_CTRL = {4'h6, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
   localparam logic [CTRL_W-1:0] S_CTRL       = {4'h0, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0};
   localparam logic [CTRL_W-1:0] B_CTRL       = {4'h1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0};
   localparam logic [CTRL_W-1:0] U_LUI_CTRL   = {4'h4, 1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0};
   localparam logic [CTRL_W-1:0] U_AUIPC_CTRL = {4'h0, 1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0};
   localparam logic [CTRL_W-1:0] J_CTRL       = {4'h0, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1};

   function automatic logic uses_rs1(input logic [6:0] op);
      return (op == OP_R) || (op == OP_I_JUMP) || (op == OP_I_LOAD) ||
             (op == OP_I_ARITH) || (op == OP_S) || (op == OP_B);
   endfunction

   function automatic logic uses_rs2(input logic [6:0] op);
      return (op == OP_R) || (op == OP_S) || (op == OP_B);
   endfunction

endpackage

// File: rtl/ctrl_pipe_decode.sv
// ctrl_decode: purely combinational opcode decoder.
//   opcode   in  7       instruction[6:0]
//   ctrl     out CTRL_W  control bundle, 0 for illegal opcodes
//   legal    out 1       opcode is one of the supported RV32I classes
//   use_rs1  out 1       instruction reads rs1
//   use_rs2  out 1       instruction reads rs2
module ctrl_decode
   import ctrl_pipe_pkg::*;
(
   input  logic [6:0]        opcode,
   output logic [CTRL_W-1:0] ctrl,
   output logic              legal,
   output logic              use_rs1,
   output logic              use_rs2
);

   always_comb begin
      ctrl  = '0;
      legal = 1'b1;
      unique case (opcode)
         OP_R:       ctrl = R_CTRL;
         OP_I_JUMP:  ctrl = I_JUMP_CTRL;
         OP_I_LOAD:  ctrl = I_LOAD_CTRL;
         OP_I_ARITH: ctrl = I_ARITH_CTRL;
         OP_I_SYS:   ctrl = I_SYS_CTRL;
         OP_I_FENCE: ctrl = I_FENCE_CTRL;
         OP_S:       ctrl = S_CTRL;
         OP_B:       ctrl = B_CTRL;
         OP_U_LUI:   ctrl = U_LUI_CTRL;
         OP_U_AUIPC: ctrl = U_AUIPC_CTRL;
         OP_J:       ctrl = J_CTRL;
         default:    legal = 1'b0;
      endcase
   end

   assign use_rs1 = uses_rs1(opcode);
   assign use_rs2 = uses_rs2(opcode);

endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: pipelined main-control unit between fetch and datapath.
//   i_clk, i_rstn            clock, synchronous active-low reset
//   i_valid, i_opcode        decode-stage instruction
//   i_rd, i_rs1, i_rs2       decode-stage register fields
//   i_stall                  external freeze of all slots
//   i_flush                  kill decode instruction, slot 0 becomes bubble
//   o_id_ctrl                combinational decode of i_opcode
//   o_stage_ctrl/rd/valid    slot k (0 = EX ... STAGES-1 = WB), ctrl at [k*11+:11]
//   o_hazard_stall           load-use stall request for fetch/decode
//   o_illegal, o_illegal_op  one-cycle trap pulse and offending opcode
//   o_retire_cnt             instructions leaving the last slot
module ctrl_pipe
   import ctrl_pipe_pkg::*;
#(
   parameter int STAGES    = 3,
   parameter int REG_AW    = 5,
   parameter int CNT_W     = 32,
   parameter int EN_HAZARD = 1
) (
   input  logic                       i_clk,
   input  logic                       i_rstn,
   input  logic                       i_valid,
   input  logic [6:0]                 i_opcode,
   input  logic [REG_AW-1:0]          i_rd,
   input  logic [REG_AW-1:0]          i_rs1,
   input  logic [REG_AW-1:0]          i_rs2,
   input  logic                       i_stall,
   input  logic                       i_flush,
   output logic [CTRL_W-1:0]          o_id_ctrl,
   output logic [STAGES*CTRL_W-1:0]   o_stage_ctrl,
   output logic [STAGES*REG_AW-1:0]   o_stage_rd,
   output logic [STAGES-1:0]          o_stage_valid,
   output logic                       o_hazard_stall,
   output logic                       o_illegal,
   output logic [6:0]                 o_illegal_op,
   output logic [CNT_W-1:0]           o_retire_cnt
);

   logic [CTRL_W-1:0] ctrl_q [STAGES];
   logic [REG_AW-1:0] rd_q   [STAGES];
   logic [STAGES-1:0] vld_pipe;

   logic              legal, use_rs1, use_rs2;
   logic              hz_raw, accept, trap;

   ctrl_decode u_dec (
      .opcode  (i_opcode),
      .ctrl    (o_id_ctrl),
      .legal   (legal),
      .use_rs1 (use_rs1),
      .use_rs2 (use_rs2)
   );

   // Load in EX whose destination is read by the decode instruction. x0 never hazards.
   assign hz_raw = i_valid & vld_pipe[0] & ctrl_q[0][MEM2REG] & (rd_q[0] != '0) &
                   (((rd_q[0] == i_rs1) & use_rs1) | ((rd_q[0] == i_rs2) & use_rs2));
   // A flush discards the consumer anyway, so it never needs to wait.
   assign o_hazard_stall = (EN_HAZARD != 0) & hz_raw & ~i_flush;

   assign accept = i_valid & legal & ~o_hazard_stall & ~i_flush;
   assign trap   = i_valid & ~legal & ~i_stall & ~i_flush & ~o_hazard_stall;

   for (genvar k = 0; k < STAGES; k++) begin : g_slot
      if (k == 0) begin : g_ex
         // flush wins over stall: slot 0 is cleared even while frozen
         always_ff @(posedge i_clk) begin
            if (!i_rstn || i_flush || (!i_stall && !accept)) begin
               ctrl_q[0]   <= '0;
               rd_q[0]     <= '0;
               vld_pipe[0] <= 1'b0;
            end else if (!i_stall) begin
               ctrl_q[0]   <= o_id_ctrl;
               rd_q[0]     <= i_rd;
               vld_pipe[0] <= 1'b1;
            end
         end
      end else begin : g_later
         always_ff @(posedge i_clk) begin
            if (!i_rstn) begin
               ctrl_q[k]   <= '0;
               rd_q[k]     <= '0;
               vld_pipe[k] <= 1'b0;
            end else if (!i_stall) begin
               ctrl_q[k]   <= ctrl_q[k-1];
               rd_q[k]     <= rd_q[k-1];
               vld_pipe[k] <= vld_pipe[k-1];
            end
         end
      end
      assign o_stage_ctrl[k*CTRL_W +: CTRL_W] = ctrl_q[k];
      assign o_stage_rd[k*REG_AW +: REG_AW]   = rd_q[k];
   end

   assign o_stage_valid = vld_pipe;

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         o_illegal    <= 1'b0;
         o_illegal_op <= '0;
         o_retire_cnt <= '0;
      end else begin
         o_illegal <= trap;
         if (trap)
            o_illegal_op <= i_opcode;
         if (!i_stall && vld_pipe[STAGES-1])
            o_retire_cnt <= o_retire_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed plus randomized bench for ctrl_pipe with a transaction-level
// reference model (slots hold opcode/rd records; control bundles rebuilt from fields).
module tb_ctrl_pipe;

   localparam int S  = 3;
   localparam int AW = 5;

   logic            i_clk = 1'b0;
   logic            i_rstn, i_valid, i_stall, i_flush;
   logic [6:0]      i_opcode;
   logic [AW-1:0]   i_rd, i_rs1, i_rs2;

   logic [10:0]     o_id_ctrl, d4_id_ctrl;
   logic [S*11-1:0] o_stage_ctrl, d4_stage_ctrl;
   logic [S*AW-1:0] o_stage_rd, d4_stage_rd;
   logic [S-1:0]    o_stage_valid, d4_stage_valid;
   logic            o_hazard_stall, o_illegal, d4_hazard_stall, d4_illegal;
   logic [6:0]      o_illegal_op, d4_illegal_op;
   logic [31:0]     o_retire_cnt;
   logic [3:0]      d4_retire_cnt;

   always #5 i_clk = ~i_clk;

   ctrl_pipe #(.STAGES(S), .REG_AW(AW), .CNT_W(32), .EN_HAZARD(1)) dut (
      .i_clk(i_clk), .i_rstn(i_rstn), .i_valid(i_valid), .i_opcode(i_opcode),
      .i_rd(i_rd), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_stall(i_stall), .i_flush(i_flush),
      .o_id_ctrl(o_id_ctrl), .o_stage_ctrl(o_stage_ctrl), .o_stage_rd(o_stage_rd),
      .o_stage_valid(o_stage_valid), .o_hazard_stall(o_hazard_stall),
      .o_illegal(o_illegal), .o_illegal_op(o_illegal_op), .o_retire_cnt(o_retire_cnt));

   ctrl_pipe #(.STAGES(S), .REG_AW(AW), .CNT_W(4), .EN_HAZARD(1)) dut4 (
      .i_clk(i_clk), .i_rstn(i_rstn), .i_valid(i_valid), .i_opcode(i_opcode),
      .i_rd(i_rd), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_stall(i_stall), .i_flush(i_flush),
      .o_id_ctrl(d4_id_ctrl), .o_stage_ctrl(d4_stage_ctrl), .o_stage_rd(d4_stage_rd),
      .o_stage_valid(d4_stage_valid), .o_hazard_stall(d4_hazard_stall),
      .o_illegal(d4_illegal), .o_illegal_op(d4_illegal_op), .o_retire_cnt(d4_retire_cnt));

   localparam logic [6:0] R = 7'h33, JALR = 7'h67, LD = 7'h03, AR = 7'h13, SYS = 7'h73,
                          FEN = 7'h0F, ST = 7'h23, BR = 7'h63, LUI = 7'h37, AUI = 7'h17,
                          JAL = 7'h6F, BAD = 7'h7F;

   int checks = 0, errors = 0;

   // reference model state
   logic [6:0]    m_op  [S];
   logic [AW-1:0] m_rd  [S];
   logic          m_vld [S];
   int unsigned   m_cnt;
   logic          m_ill;
   logic [6:0]    m_ill_op;
   bit            m_init = 0;

   function automatic logic [10:0] mk(input int alu, input bit a, b, mw, rw, m2r, br, j);
      return {alu[3:0], a, b, mw, rw, m2r, br, j};
   endfunction

   function automatic bit is_legal(input logic [6:0] op);
      return op inside {R, JALR, LD, AR, SYS, FEN, ST, BR, LUI, AUI, JAL};
   endfunction

   function automatic logic [10:0] exp_ctrl(input logic [6:0] op);
      case (op)
         R:    return mk(2, 0,0,0,1,0,0,0);
         JALR: return mk(0, 0,1,0,1,0,0,1);
         LD:   return mk(0, 0,1,0,1,1,0,0);
         AR:   return mk(3, 0,1,0,1,0,0,0);
         SYS:  return mk(5, 0,0,0,0,0,0,0);
         FEN:  return mk(6, 0,0,0,0,0,0,0);
         ST:   return mk(0, 0,1,1,0,0,0,0);
         BR:   return mk(1, 0,0,0,0,0,1,0);
         LUI:  return mk(4, 0,1,0,1,0,0,0);
         AUI:  return mk(0, 1,1,0,1,0,0,0);
         JAL:  return mk(0, 1,0,0,1,0,0,1);
         default: return 11'd0;
      endcase
   endfunction

   function automatic bit model_hz();
      bit r1, r2;
      r1 = i_opcode inside {R, JALR, LD, AR, ST, BR};
      r2 = i_opcode inside {R, ST, BR};
      return i_valid && !i_flush && m_vld[0] && m_op[0] == LD && m_rd[0] != 0 &&
             ((m_rd[0] == i_rs1 && r1) || (m_rd[0] == i_rs2 && r2));
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input bit hz);
      bit accept, trap;
      if (!i_rstn) begin
         for (int k = 0; k < S; k++) begin m_op[k] = 0; m_rd[k] = 0; m_vld[k] = 0; end
         m_cnt = 0; m_ill = 0; m_ill_op = 0; m_init = 1;
         return;
      end
      if (!m_init) return;
      accept = i_valid && is_legal(i_opcode) && !hz && !i_flush;
      trap   = i_valid && !is_legal(i_opcode) && !i_stall && !i_flush && !hz;
      if (!i_stall) begin
         if (m_vld[S-1]) m_cnt++;
         for (int k = S-1; k > 0; k--) begin
            m_op[k] = m_op[k-1]; m_rd[k] = m_rd[k-1]; m_vld[k] = m_vld[k-1];
         end
         m_vld[0] = accept;
         m_op[0]  = accept ? i_opcode : 7'd0;
         m_rd[0]  = accept ? i_rd : '0;
      end else if (i_flush) begin
         m_vld[0] = 0; m_op[0] = 0; m_rd[0] = 0;
      end
      m_ill = trap;
      if (trap) m_ill_op = i_opcode;
   endtask

   task automatic check_state();
      logic [S*11-1:0] ec;
      logic [S*AW-1:0] er;
      logic [S-1:0]    ev;
      for (int k = 0; k < S; k++) begin
         ec[k*11 +: 11] = m_vld[k] ? exp_ctrl(m_op[k]) : 11'd0;
         er[k*AW +: AW] = m_vld[k] ? m_rd[k] : '0;
         ev[k]          = m_vld[k];
      end
      chk("stage_ctrl", 64'(o_stage_ctrl), 64'(ec));
      chk("stage_rd", 64'(o_stage_rd), 64'(er));
      chk("stage_valid", 64'(o_stage_valid), 64'(ev));
      chk("illegal", 64'(o_illegal), 64'(m_ill));
      chk("illegal_op", 64'(o_illegal_op), 64'(m_ill_op));
      chk("retire_cnt", 64'(o_retire_cnt), 64'(m_cnt));
      chk("retire_cnt4", 64'(d4_retire_cnt), 64'(m_cnt % 16));
   endtask

   task automatic step(input bit rn, v, input logic [6:0] op, input int rd, rs1, rs2,
                       input bit st, fl);
      bit hz;
      i_rstn = rn; i_valid = v; i_opcode = op; i_rd = AW'(rd); i_rs1 = AW'(rs1);
      i_rs2 = AW'(rs2); i_stall = st; i_flush = fl;
      #1;
      chk("id_ctrl", 64'(o_id_ctrl), 64'(exp_ctrl(op)));
      hz = model_hz();
      if (m_init) chk("hazard", 64'(o_hazard_stall), 64'(hz));
      @(posedge i_clk);
      model_edge(hz);
      #1;
      if (m_init) check_state();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 7'd0, 0, 0, 0, 0, 0);
   endtask

   logic [6:0] ops [12] = '{R, JALR, LD, AR, SYS, FEN, ST, BR, LUI, AUI, JAL, BAD};

   initial begin
      i_rstn = 0; i_valid = 0; i_opcode = 0; i_rd = 0; i_rs1 = 0; i_rs2 = 0;
      i_stall = 0; i_flush = 0;
      @(posedge i_clk); #1;

      // reset held two cycles with a valid R instruction, then release
      step(0, 1, R, 3, 1, 2, 0, 0);
      step(0, 1, R, 3, 1, 2, 0, 0);
      chk("rst_valid", 64'(o_stage_valid), 64'd0);
      chk("rst_cnt", 64'(o_retire_cnt), 64'd0);
      step(1, 1, R, 3, 1, 2, 0, 0);
      chk("rel_slot0", 64'(o_stage_ctrl[10:0]), 64'(mk(2, 0,0,0,1,0,0,0)));
      idle(4);

      // load-use: one stall, bubble, consumer enters next cycle
      step(1, 1, LD, 5, 1, 0, 0, 0);
      i_valid = 1; i_opcode = R; i_rs1 = 5; #1;
      chk("lu_stall", 64'(o_hazard_stall), 64'd1);
      step(1, 1, R, 6, 5, 0, 0, 0);
      chk("lu_bubble", 64'(o_stage_valid[0]), 64'd0);
      step(1, 1, R, 6, 5, 0, 0, 0);
      chk("lu_enter", 64'(o_stage_rd[AW-1:0]), 64'd6);

      // no false hazards: rd=x0, and LUI ignores its rs1 field
      step(1, 1, LD, 0, 1, 0, 0, 0);
      step(1, 1, R, 7, 0, 0, 0, 0);
      step(1, 1, LD, 5, 1, 0, 0, 0);
      step(1, 1, LUI, 8, 5, 5, 0, 0);
      chk("lui_nohz", 64'(o_stage_valid[0]), 64'd1);
      idle(3);

      // illegal opcode trap; suppressed while stalled
      step(1, 1, BAD, 1, 0, 0, 0, 0);
      chk("trap_pulse", 64'(o_illegal), 64'd1);
      chk("trap_op", 64'(o_illegal_op), 64'h7F);
      step(1, 0, 7'd0, 0, 0, 0, 0, 0);
      chk("trap_once", 64'(o_illegal), 64'd0);
      step(1, 1, BAD, 1, 0, 0, 1, 0);
      chk("trap_stall", 64'(o_illegal), 64'd0);

      // freeze 3 cycles with flush in the middle one
      step(1, 1, AR, 1, 0, 0, 0, 0);
      step(1, 1, ST, 2, 0, 0, 0, 0);
      step(1, 1, JAL, 3, 0, 0, 0, 0);
      step(1, 1, R, 4, 0, 0, 1, 0);
      step(1, 1, R, 4, 0, 0, 1, 1);
      step(1, 1, R, 4, 0, 0, 1, 0);
      chk("frz_slot0", 64'(o_stage_valid[0]), 64'd0);
      chk("frz_slot2", 64'(o_stage_rd[2*AW +: AW]), 64'd1);
      idle(4);

      // retire counting: 10 instructions, 13 cycles
      step(0, 0, 7'd0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) step(1, 1, R, 1, 0, 0, 0, 0);
      idle(3);
      chk("ret10", 64'(o_retire_cnt), 64'd10);
      step(0, 0, 7'd0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 17; i++) step(1, 1, AR, 2, 0, 0, 0, 0);
      idle(3);
      chk("ret17_w4", 64'(d4_retire_cnt), 64'd1);
      chk("ret17", 64'(o_retire_cnt), 64'd17);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         int sel;
         logic [6:0] op;
         sel = $urandom_range(0, 12);
         op  = (sel == 12) ? 7'($urandom) : ops[sel];
         step($urandom_range(0, 49) != 0, $urandom_range(0, 5) != 0, op,
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
